// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// BCD limits and default timing.
package stopwatch_ctrl_pkg;

  // Controller states; the encoding is visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Largest value a single BCD digit may hold.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Number of cascaded digits; the display bus is sized for exactly four.
  localparam int NDIG = 4;

  // 100 MHz system clock divided down to a 0.01 s count tick.
  localparam int DEFAULT_TICK_DIV = 1000000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the board controls and the stopwatch.
//
// Handshake: there is no valid/ready pair here. start_stop, clear and lap
// are single-cycle command pulses that the controller samples on every
// rising clock edge; each high cycle is one command. The status outputs
// are level signals that are always valid.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] digits;
  logic        running;
  logic        lap_active;
  logic        overflow;
  state_t      dbgState;

  // Command source (board controls / testbench).
  modport master (
    output start_stop, clear, lap,
    input  digits, running, lap_active, overflow, dbgState
  );

  // The stopwatch controller itself.
  modport slave (
    input  start_stop, clear, lap,
    output digits, running, lap_active, overflow, dbgState
  );
endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_cell.sv
// One mod-10 counter stage of the cascaded BCD chain.
module bcd_digit_cell
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry_out
);

  // The next stage advances only when this one wraps from 9 back to 0.
  assign carry_out = inc && (digit == BCD_MAX);

  // Count 0..9 on inc, wrap to 0, otherwise hold; clear beats inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: prescaler, start/stop/clear/lap state machine and a
// four-digit BCD counter chain with a freezable lap display.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t              state;
  state_t              nextState;
  logic [PW-1:0]       prescaler;
  logic                tick;
  logic                running;
  logic                lapActive;
  logic                overflow;
  logic                lapEvent;
  logic                wrap;
  logic [4*NDIG-1:0]   liveCount;
  logic [4*NDIG-1:0]   dispReg;
  logic [NDIG:0]       incChain;

  // One-cycle count strobe on the last prescaler step while running.
  assign tick = (state == ST_RUN) && (prescaler == PRE_LAST);

  // Carry chain: every digit sees the tick on the same edge, gated by
  // all lower digits being 9, so the whole count updates at once.
  assign incChain[0] = tick;
  assign wrap        = incChain[NDIG];

  for (genvar k = 0; k < NDIG; k++) begin : gDigit
    bcd_digit_cell uCell (
      .clk       (clk),
      .rst       (rst),
      .clr       (bus.clear),
      .inc       (incChain[k]),
      .digit     (liveCount[4*k +: 4]),
      .carry_out (incChain[k+1])
    );
  end

  // Prescaler runs only in RUN, holds in PAUSE, and restarts from zero on
  // clear so a cleared run never inherits a partial tick.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      prescaler <= '0;
    end else if (state == ST_RUN) begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
    end else if (state == ST_IDLE) begin
      prescaler <= '0;
    end
  end

  // Next-state selection: clear wins over start_stop.
  always_comb begin
    nextState = state;
    if (bus.clear) begin
      nextState = ST_IDLE;
    end else if (bus.start_stop) begin
      case (state)
        ST_IDLE:  nextState = ST_RUN;
        ST_RUN:   nextState = ST_PAUSE;
        ST_PAUSE: nextState = ST_RUN;
        default:  nextState = ST_IDLE;
      endcase
    end
  end

  // A lap pulse counts only outside IDLE and when no higher-priority
  // command arrives in the same cycle.
  assign lapEvent = bus.lap && !bus.clear && !bus.start_stop && (state != ST_IDLE);

  // State register with registered status flags and the lap snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      lapActive <= 1'b0;
      dispReg   <= '0;
      overflow  <= 1'b0;
    end else begin
      state   <= nextState;
      running <= (nextState == ST_RUN);
      if (bus.clear) begin
        lapActive <= 1'b0;
        dispReg   <= '0;
        overflow  <= 1'b0;
      end else begin
        if (lapEvent) begin
          if (!lapActive) begin
            dispReg   <= liveCount;
            lapActive <= 1'b1;
          end else begin
            lapActive <= 1'b0;
          end
        end
        if (wrap) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Live count passes straight through unless a lap snapshot is held.
  assign bus.digits     = lapActive ? dispReg : liveCount;
  assign bus.running    = running;
  assign bus.lap_active = lapActive;
  assign bus.overflow   = overflow;
  assign bus.dbgState   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a short tick divider.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_ctrl_if swIf ();

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (swIf.slave)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;
  bit autoCheck = 1'b0;
  logic [15:0] exp_q[$];

  // ---------------- behavioural model ----------------
  int mMode, mPre, mCount, mFrozenVal;
  bit mFrozen, mOvf;

  function automatic logic [15:0] toBcd(input int v);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'((v / 1000) % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic mdlZero();
    mMode = M_IDLE; mPre = 0; mCount = 0;
    mFrozen = 0; mFrozenVal = 0; mOvf = 0;
  endtask

  task automatic mdlStep(input logic r, input logic ss, input logic cl, input logic lp);
    int old;
    if (r || cl) begin
      mdlZero();
      return;
    end
    old = mCount;
    if (mMode == M_RUN) begin
      if (mPre == TD - 1) begin
        mPre = 0;
        mCount = (mCount + 1) % 10000;
        if (mCount == 0) mOvf = 1;
      end else begin
        mPre++;
      end
    end
    if (ss) begin
      mMode = (mMode == M_RUN) ? M_PAUSE : M_RUN;
    end else if (lp && mMode != M_IDLE) begin
      if (!mFrozen) begin
        mFrozen = 1;
        mFrozenVal = old;
      end else begin
        mFrozen = 0;
      end
    end
  endtask

  // ---------------- checkers ----------------
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic compareModel(input string name);
    exp_q.push_back(toBcd(mFrozen ? mFrozenVal : mCount));
    chk({name, "_digits"}, swIf.digits, exp_q.pop_front());
    chk({name, "_running"}, 16'(swIf.running), 16'(mMode == M_RUN));
    chk({name, "_lap"}, 16'(swIf.lap_active), 16'(mFrozen));
    chk({name, "_ovf"}, 16'(swIf.overflow), 16'(mOvf));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic ss, input logic cl, input logic lp);
    rst = r; swIf.start_stop = ss; swIf.clear = cl; swIf.lap = lp;
    mdlStep(r, ss, cl, lp);
    @(posedge clk);
    #1;
    rst = 1'b0; swIf.start_stop = 1'b0; swIf.clear = 1'b0; swIf.lap = 1'b0;
    if (autoCheck) compareModel("rand");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic runUntil(input int target, input int budget, input string name);
    int n = 0;
    while (mCount != target && n < budget) begin
      cycle(0, 0, 0, 0);
      n++;
    end
    if (mCount != target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=%0d exp=%0d", name, mCount, target);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic r, ss, cl, lp;
    logic [15:0] dig;
    logic run, lapA, ovf;
  } vec_t;
  vec_t vecs[19];

  initial begin
    rst = 1'b1;
    swIf.start_stop = 1'b0; swIf.clear = 1'b0; swIf.lap = 1'b0;
    mdlZero();

    //           r  ss cl lp  digits     run lap ovf
    vecs[0]  = '{1, 0, 0, 0, 16'h0000, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 16'h0000, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 16'h0000, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 16'h0001, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 16'h0001, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 16'h0001, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 16'h0001, 1, 1, 0};
    vecs[9]  = '{0, 0, 0, 0, 16'h0001, 1, 1, 0};
    vecs[10] = '{0, 0, 0, 1, 16'h0002, 1, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 16'h0002, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 16'h0002, 0, 1, 0};
    vecs[13] = '{0, 1, 0, 0, 16'h0002, 1, 1, 0};
    vecs[14] = '{0, 0, 0, 0, 16'h0002, 1, 1, 0};
    vecs[15] = '{0, 0, 0, 0, 16'h0002, 1, 1, 0};
    vecs[16] = '{0, 0, 0, 1, 16'h0003, 1, 0, 0};
    vecs[17] = '{0, 1, 1, 0, 16'h0000, 0, 0, 0};
    vecs[18] = '{0, 0, 0, 1, 16'h0000, 0, 0, 0};

    @(posedge clk);
    #1;

    // Table-driven sequence: reset, first tick, lap freeze, pause, clear.
    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].r, vecs[i].ss, vecs[i].cl, vecs[i].lp);
      chk($sformatf("vec%0d_digits", i), swIf.digits, vecs[i].dig);
      chk($sformatf("vec%0d_running", i), 16'(swIf.running), 16'(vecs[i].run));
      chk($sformatf("vec%0d_lap", i), 16'(swIf.lap_active), 16'(vecs[i].lapA));
      chk($sformatf("vec%0d_ovf", i), 16'(swIf.overflow), 16'(vecs[i].ovf));
    end
    chk("idle_state", 16'(swIf.dbgState), 16'(ST_IDLE));

    // Carry into digit1 after 40 running cycles.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(39);
    chk("pre_carry", swIf.digits, 16'h0009);
    idle(1);
    chk("carry_digit1", swIf.digits, 16'h0010);
    chk("carry_running", 16'(swIf.running), 16'd1);

    // Pause at 0009 with prescaler at 3, hold, then resume on the last step.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    idle(38);
    cycle(0, 1, 0, 0);
    idle(20);
    chk("pause_hold", swIf.digits, 16'h0009);
    chk("pause_state", 16'(swIf.dbgState), 16'(ST_PAUSE));
    cycle(0, 1, 0, 0);
    chk("resume_same", swIf.digits, 16'h0009);
    idle(1);
    chk("resume_tick", swIf.digits, 16'h0010);

    // Wrap 9999 -> 0000 with sticky overflow.
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    runUntil(9999, 40010, "to9999");
    chk("at9999", swIf.digits, 16'h9999);
    chk("no_ovf_yet", 16'(swIf.overflow), 16'd0);
    idle(4);
    chk("wrap_digits", swIf.digits, 16'h0000);
    chk("wrap_ovf", 16'(swIf.overflow), 16'd1);
    idle(8);
    chk("post_wrap_digits", swIf.digits, 16'h0002);
    chk("ovf_sticky", 16'(swIf.overflow), 16'd1);
    cycle(0, 0, 1, 0);
    chk("clr_ovf", 16'(swIf.overflow), 16'd0);
    chk("clr_digits", swIf.digits, 16'h0000);
    chk("clr_state", 16'(swIf.dbgState), 16'(ST_IDLE));

    // Lap freeze at 0123 while the count advances to 0131.
    cycle(0, 1, 0, 0);
    runUntil(123, 600, "to0123");
    cycle(0, 0, 0, 1);
    chk("lap_frozen", swIf.digits, 16'h0123);
    runUntil(131, 100, "to0131");
    chk("lap_still_frozen", swIf.digits, 16'h0123);
    chk("lap_flag", 16'(swIf.lap_active), 16'd1);
    cycle(0, 0, 0, 1);
    chk("lap_release", swIf.digits, 16'h0131);
    chk("lap_flag_off", 16'(swIf.lap_active), 16'd0);

    // Reset in the middle of a run at 0456.
    runUntil(456, 1400, "to0456");
    idle(2);
    cycle(1, 0, 0, 0);
    chk("rst_digits", swIf.digits, 16'h0000);
    chk("rst_running", 16'(swIf.running), 16'd0);
    chk("rst_state", 16'(swIf.dbgState), 16'(ST_IDLE));

    // Random command stream against the model.
    autoCheck = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
    end
    autoCheck = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
